// File: rtl/fir_coeff_sequencer_if.sv
// Handshake and filter-write bus between a coefficient source, the sequencer and the FIR.
// The master side is the controller and source; the slave side is the sequencer.
interface fir_coeff_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] tap_count;
  logic       coef_in_valid;
  logic [7:0] coef_in_data;
  logic       coef_in_ready;
  logic [3:0] coefficient_number;
  logic [7:0] coefficient_value;
  logic       coefficient_write_enable;
  logic       flush_active;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, abort, tap_count, coef_in_valid, coef_in_data,
    input  coef_in_ready, coefficient_number, coefficient_value, coefficient_write_enable,
    input  flush_active, busy, done, error
  );

  modport slave (
    input  start, abort, tap_count, coef_in_valid, coef_in_data,
    output coef_in_ready, coefficient_number, coefficient_value, coefficient_write_enable,
    output flush_active, busy, done, error
  );
endinterface

// File: rtl/fir_coeff_sequencer.sv
// Loads user coefficients into an FIR, zero-fills the unused taps, then flushes the
// filter pipeline with zero input before signalling completion.
module fir_coeff_sequencer #(
  parameter int unsigned MAX_TAPS     = 10,
  parameter int unsigned FLUSH_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_coeff_sequencer_if.slave   bus
);

  localparam int unsigned CntW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FLUSH_CYCLES - 1);
  localparam logic [4:0]      MaxTaps = 5'(MAX_TAPS);
  localparam logic [3:0]      LastIdx = 4'(MAX_TAPS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StZfill, StFlush, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      tap_q, tap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      num_q, num_d;
  logic [7:0]      val_q, val_d;
  logic            err_q, err_d;
  logic            tap_ok;

  assign tap_ok = (bus.tap_count != 4'd0) && ({1'b0, bus.tap_count} <= MaxTaps);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tap_d   = tap_q;
    cnt_d   = '0;
    we_d    = 1'b0;
    num_d   = num_q;
    val_d   = val_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (bus.start && !bus.abort) begin
          if (tap_ok) begin
            tap_d   = bus.tap_count;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (bus.coef_in_valid) begin
          we_d  = 1'b1;
          num_d = idx_q;
          val_d = bus.coef_in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == tap_q - 4'd1) begin
            state_d = ({1'b0, tap_q} < MaxTaps) ? StZfill : StFlush;
          end
        end
      end
      StZfill: begin
        we_d  = 1'b1;
        num_d = idx_q;
        val_d = '0;
        idx_d = idx_q + 4'd1;
        if (idx_q == LastIdx) state_d = StFlush;
      end
      StFlush: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort also cancels a write that would otherwise register on this edge.
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
      we_d    = 1'b0;
      num_d   = num_q;
      val_d   = val_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tap_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      num_q   <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      num_q   <= num_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign bus.coef_in_ready            = (state_q == StLoad);
  assign bus.coefficient_number       = num_q;
  assign bus.coefficient_value        = val_q;
  assign bus.coefficient_write_enable = we_q;
  assign bus.flush_active             = (state_q == StFlush);
  assign bus.busy                     = (state_q != StIdle);
  assign bus.done                     = (state_q == StDone);
  assign bus.error                    = err_q;

endmodule
